// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of one strict-aligned memory: combinational grant,
// a single registered issue stage, and per-port responses one cycle after issue.
package mem_pkg;
  typedef enum logic [1:0] {
    MEM_DT_WORD = 2'd0,
    MEM_DT_HALF = 2'd1,
    MEM_DT_BYTE = 2'd2
  } mem_dt_e;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_ALIGN = 2'd1
  } errno_e;
endpackage

module mem_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned N  = 64,
  parameter bit          RR = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p0_req,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wd,
  input  logic        p0_we,
  input  mem_dt_e     p0_dt,
  output logic        p0_gnt,
  output logic        p0_ack,
  output logic [31:0] p0_rd,
  output logic        p0_err,
  input  logic        p1_req,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wd,
  input  logic        p1_we,
  input  mem_dt_e     p1_dt,
  output logic        p1_gnt,
  output logic        p1_ack,
  output logic [31:0] p1_rd,
  output logic        p1_err,
  output logic [31:0] m_addr,
  output logic [31:0] m_wd,
  output logic        m_we,
  output mem_dt_e     m_dt,
  input  logic [31:0] m_rd,
  input  errno_e      m_err
);

  logic        last;
  logic        s_valid;
  logic        s_port;
  logic [31:0] s_addr;
  logic [31:0] s_wd;
  logic        s_we;
  mem_dt_e     s_dt;
  logic        bad;
  logic        any_gnt;

  // last holds the index of the most recently granted port; a tie goes to the other one
  always_comb begin
    p0_gnt = 1'b0;
    p1_gnt = 1'b0;
    if (rst_n) begin
      if (p0_req && p1_req) begin
        if (RR && !last) p1_gnt = 1'b1;
        else             p0_gnt = 1'b1;
      end else begin
        p0_gnt = p0_req;
        p1_gnt = p1_req;
      end
    end
  end

  assign any_gnt = p0_gnt | p1_gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last    <= 1'b1;
      s_valid <= 1'b0;
      s_port  <= 1'b0;
      s_addr  <= '0;
      s_wd    <= '0;
      s_we    <= 1'b0;
      s_dt    <= MEM_DT_WORD;
    end else begin
      s_valid <= any_gnt;
      if (any_gnt) begin
        last   <= p1_gnt;
        s_port <= p1_gnt;
        s_addr <= p1_gnt ? p1_addr : p0_addr;
        s_wd   <= p1_gnt ? p1_wd   : p0_wd;
        s_we   <= p1_gnt ? p1_we   : p0_we;
        s_dt   <= p1_gnt ? p1_dt   : p0_dt;
      end
    end
  end

  assign bad    = (m_err != ERR_NONE) || ({2'b00, s_addr[31:2]} >= N);
  assign m_addr = s_addr;
  assign m_wd   = s_wd;
  assign m_dt   = s_dt;
  assign m_we   = s_valid & s_we & ~bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p0_ack <= 1'b0;
      p0_rd  <= '0;
      p0_err <= 1'b0;
      p1_ack <= 1'b0;
      p1_rd  <= '0;
      p1_err <= 1'b0;
    end else begin
      p0_ack <= s_valid & ~s_port;
      p1_ack <= s_valid & s_port;
      if (s_valid && !s_port) begin
        p0_rd  <= (s_we | bad) ? '0 : m_rd;
        p0_err <= bad;
      end
      if (s_valid && s_port) begin
        p1_rd  <= (s_we | bad) ? '0 : m_rd;
        p1_err <= bad;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural memory, directed vector table, hand sequences
// and a randomized run scored against a byte-level reference model.
module tb_mem_arbiter;
  import mem_pkg::*;

  localparam int unsigned N = 64;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        req  [2];
  logic [31:0] addr [2];
  logic [31:0] wd   [2];
  logic        we   [2];
  mem_dt_e     dt   [2];

  logic        p0_gnt, p0_ack, p0_err, p1_gnt, p1_ack, p1_err;
  logic [31:0] p0_rd, p1_rd;
  logic [31:0] m_addr, m_wd, m_rd;
  logic        m_we;
  mem_dt_e     m_dt;
  errno_e      m_err;

  logic        fp_p0_gnt, fp_p0_ack, fp_p0_err, fp_p1_gnt, fp_p1_ack, fp_p1_err;
  logic [31:0] fp_p0_rd, fp_p1_rd, fp_m_addr, fp_m_wd;
  logic        fp_m_we;
  mem_dt_e     fp_m_dt;

  mem_arbiter #(.N(N), .RR(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(req[0]), .p0_addr(addr[0]), .p0_wd(wd[0]), .p0_we(we[0]), .p0_dt(dt[0]),
    .p0_gnt(p0_gnt), .p0_ack(p0_ack), .p0_rd(p0_rd), .p0_err(p0_err),
    .p1_req(req[1]), .p1_addr(addr[1]), .p1_wd(wd[1]), .p1_we(we[1]), .p1_dt(dt[1]),
    .p1_gnt(p1_gnt), .p1_ack(p1_ack), .p1_rd(p1_rd), .p1_err(p1_err),
    .m_addr(m_addr), .m_wd(m_wd), .m_we(m_we), .m_dt(m_dt), .m_rd(m_rd), .m_err(m_err)
  );

  mem_arbiter #(.N(N), .RR(1'b0)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .p0_req(req[0]), .p0_addr(addr[0]), .p0_wd(wd[0]), .p0_we(we[0]), .p0_dt(dt[0]),
    .p0_gnt(fp_p0_gnt), .p0_ack(fp_p0_ack), .p0_rd(fp_p0_rd), .p0_err(fp_p0_err),
    .p1_req(req[1]), .p1_addr(addr[1]), .p1_wd(wd[1]), .p1_we(we[1]), .p1_dt(dt[1]),
    .p1_gnt(fp_p1_gnt), .p1_ack(fp_p1_ack), .p1_rd(fp_p1_rd), .p1_err(fp_p1_err),
    .m_addr(fp_m_addr), .m_wd(fp_m_wd), .m_we(fp_m_we), .m_dt(fp_m_dt),
    .m_rd(32'h0), .m_err(ERR_NONE)
  );

  // Behavioural strict-aligned memory: async read, sync write, index wraps at N words
  logic [31:0] mem_w [N];
  logic [31:0] mw;
  bit          mem_init = 1'b0;

  always_comb begin
    mw    = mem_w[m_addr[7:2]];
    m_err = ERR_NONE;
    m_rd  = mw;
    case (m_dt)
      MEM_DT_BYTE: m_rd = (mw >> {m_addr[1:0], 3'b000}) & 32'h0000_00FF;
      MEM_DT_HALF: begin
        m_rd = (mw >> {m_addr[1], 4'b0000}) & 32'h0000_FFFF;
        if (m_addr[0]) m_err = ERR_ALIGN;
      end
      default: if (m_addr[1:0] != 2'b00) m_err = ERR_ALIGN;
    endcase
  end

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < N; i++) mem_w[i] <= '0;
      mem_init <= 1'b1;
    end else if (m_we) begin
      case (m_dt)
        MEM_DT_BYTE: mem_w[m_addr[7:2]][{m_addr[1:0], 3'b000} +: 8]  <= m_wd[7:0];
        MEM_DT_HALF: mem_w[m_addr[7:2]][{m_addr[1], 4'b0000} +: 16] <= m_wd[15:0];
        default:     mem_w[m_addr[7:2]] <= m_wd;
      endcase
    end
  end

  // Reference model state
  typedef struct {
    int unsigned due;
    bit          port;
    logic [31:0] rd;
    bit          err;
  } resp_t;

  logic [7:0]  ref_mem [N*4];
  resp_t       pend[$];
  bit          last_gnt;
  bit          exp_mwe;
  bit          granted [2];
  logic [31:0] rd_hold [2];
  bit          err_exp [2];
  int unsigned cyc = 0;
  logic        dut_g1, fp_g0, fp_g1;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Byte-array view of memory; a request is bad when misaligned for its size or beyond N words
  task automatic model_access(input int k, output logic [31:0] rd, output bit err, output bit wr);
    int unsigned a, n;
    a   = addr[k];
    n   = (dt[k] == MEM_DT_BYTE) ? 1 : (dt[k] == MEM_DT_HALF) ? 2 : 4;
    err = ((a % n) != 0) || ((a / 4) >= N);
    wr  = we[k] && !err;
    rd  = '0;
    if (!err) begin
      for (int unsigned i = 0; i < n; i++) begin
        if (we[k]) ref_mem[a + i] = 8'(wd[k] >> (8 * i));
        else       rd = rd | (32'(ref_mem[a + i]) << (8 * i));
      end
    end
  endtask

  task automatic step();
    bit g0, g1, e, w, nxt_mwe, a0, a1;
    logic [31:0] r;
    resp_t rs;
    @(negedge clk);
    if (req[0] && req[1]) begin
      g0 = last_gnt;
      g1 = !last_gnt;
    end else begin
      g0 = req[0];
      g1 = req[1];
    end
    dut_g1 = p1_gnt;
    fp_g0  = fp_p0_gnt;
    fp_g1  = fp_p1_gnt;
    check("p0_gnt", p0_gnt, g0);
    check("p1_gnt", p1_gnt, g1);
    check("fp_p0_gnt", fp_p0_gnt, req[0]);
    check("fp_p1_gnt", fp_p1_gnt, req[1] & ~req[0]);
    check("m_we", m_we, exp_mwe);
    nxt_mwe = 1'b0;
    if (g0 || g1) begin
      last_gnt = g1;
      model_access(g1 ? 1 : 0, r, e, w);
      pend.push_back('{cyc + 2, g1, r, e});
      nxt_mwe = w;
    end
    granted[0] = g0;
    granted[1] = g1;
    @(posedge clk);
    #1;
    cyc++;
    exp_mwe = nxt_mwe;
    a0 = 1'b0;
    a1 = 1'b0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      rs = pend.pop_front();
      if (rs.port) a1 = 1'b1; else a0 = 1'b1;
      rd_hold[rs.port] = rs.rd;
      err_exp[rs.port] = rs.err;
    end
    check("p0_ack", p0_ack, a0);
    check("p1_ack", p1_ack, a1);
    check("p0_rd", p0_rd, rd_hold[0]);
    check("p1_rd", p1_rd, rd_hold[1]);
    if (a0) check("p0_err", p0_err, err_exp[0]);
    if (a1) check("p1_err", p1_err, err_exp[1]);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    pend.delete();
    last_gnt   = 1'b1;
    exp_mwe    = 1'b0;
    rd_hold[0] = '0;
    rd_hold[1] = '0;
    #1;
    check("rst_p0_gnt", p0_gnt, 0);
    check("rst_p1_gnt", p1_gnt, 0);
    check("rst_m_addr", m_addr, 0);
    check("rst_m_wd", m_wd, 0);
    check("rst_m_we", m_we, 0);
    check("rst_m_dt", m_dt, 0);
    check("rst_p0_rd", p0_rd, 0);
    check("rst_p1_rd", p1_rd, 0);
    check("rst_p0_err", p0_err, 0);
    check("rst_p1_err", p1_err, 0);
    @(posedge clk);
    #1;
    check("rst_p0_ack", p0_ack, 0);
    check("rst_p1_ack", p1_ack, 0);
    req[0] = 1'b0;
    req[1] = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit          port;
    bit          we;
    mem_dt_e     dt;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  task automatic single(input vec_t v, input int idx);
    int k;
    k       = v.port ? 1 : 0;
    addr[k] = v.addr;
    wd[k]   = v.wd;
    we[k]   = v.we;
    dt[k]   = v.dt;
    req[k]  = 1'b1;
    step();
    req[k] = 1'b0;
    step();
    check($sformatf("vec%0d_ack", idx), v.port ? p1_ack : p0_ack, 1);
    check($sformatf("vec%0d_rd", idx), v.port ? p1_rd : p0_rd, v.exp_rd);
    check($sformatf("vec%0d_err", idx), v.port ? p1_err : p0_err, v.exp_err);
  endtask

  task automatic rand_port(input int k);
    int unsigned off;
    req[k] = ($urandom_range(0, 3) != 0);
    we[k]  = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 2))
      0:       dt[k] = MEM_DT_BYTE;
      1:       dt[k] = MEM_DT_HALF;
      default: dt[k] = MEM_DT_WORD;
    endcase
    if ($urandom_range(0, 3) == 0)     off = $urandom_range(0, 3);
    else if (dt[k] == MEM_DT_BYTE)     off = $urandom_range(0, 3);
    else if (dt[k] == MEM_DT_HALF)     off = 2 * $urandom_range(0, 1);
    else                               off = 0;
    addr[k] = $urandom_range(0, N + 1) * 4 + off;
    wd[k]   = $urandom;
  endtask

  vec_t vecs [13];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b0, 1'b1, MEM_DT_WORD, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 1'b0, MEM_DT_WORD, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, MEM_DT_HALF, 32'h11,  32'h12345678, 32'h0,        1'b1};
    vecs[3]  = '{1'b1, 1'b1, MEM_DT_WORD, 32'h12,  32'h12345678, 32'h0,        1'b1};
    vecs[4]  = '{1'b0, 1'b0, MEM_DT_WORD, N * 4,   32'h0,        32'h0,        1'b1};
    vecs[5]  = '{1'b1, 1'b0, MEM_DT_WORD, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, MEM_DT_BYTE, 32'h22,  32'h000000AB, 32'h0,        1'b0};
    vecs[7]  = '{1'b1, 1'b0, MEM_DT_HALF, 32'h22,  32'h0,        32'h000000AB, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, MEM_DT_WORD, 32'h20,  32'h0,        32'h00AB0000, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, MEM_DT_BYTE, 32'h23,  32'h0,        32'h0,        1'b0};
    vecs[10] = '{1'b1, 1'b1, MEM_DT_WORD, 32'h104, 32'h77777777, 32'h0,        1'b1};
    vecs[11] = '{1'b0, 1'b0, MEM_DT_WORD, 32'h04,  32'h0,        32'h0,        1'b0};
    vecs[12] = '{1'b0, 1'b1, MEM_DT_WORD, 32'h30,  32'h00000011, 32'h0,        1'b0};

    for (int i = 0; i < N * 4; i++) ref_mem[i] = 8'h00;
    for (int k = 0; k < 2; k++) begin
      req[k]  = 1'b1;
      addr[k] = 32'h44;
      wd[k]   = 32'hFFFF_FFFF;
      we[k]   = 1'b1;
      dt[k]   = MEM_DT_HALF;
      granted[k] = 1'b0;
      err_exp[k] = 1'b0;
    end
    do_reset();

    // Round-robin tie: continuous requests from both ports alternate starting with port 0
    addr[0] = 32'h0; we[0] = 1'b0; dt[0] = MEM_DT_WORD; req[0] = 1'b1;
    addr[1] = 32'h4; we[1] = 1'b0; dt[1] = MEM_DT_WORD; req[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("rr_p1_gnt", dut_g1, i % 2);
    end
    req[0] = 1'b0;
    req[1] = 1'b0;
    repeat (2) step();

    // Fixed priority: port 0 keeps winning until it drops its request
    req[0] = 1'b1;
    req[1] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("fp_p0_win", fp_g0, 1);
      check("fp_p1_wait", fp_g1, 0);
    end
    req[0] = 1'b0;
    step();
    check("fp_p1_after", fp_g1, 1);
    req[1] = 1'b0;
    repeat (2) step();

    for (int i = 0; i < 13; i++) single(vecs[i], i);

    // Reset asserted mid issue cycle of a write: the write and its ack are lost
    addr[0] = 32'h30; wd[0] = 32'h55; we[0] = 1'b1; dt[0] = MEM_DT_WORD; req[0] = 1'b1;
    step();
    req[0] = 1'b0;
    #2;
    check("rst_mwe_pre", m_we, 1);
    do_reset();
    ref_mem[32'h30] = 8'h11;
    ref_mem[32'h31] = 8'h00;
    ref_mem[32'h32] = 8'h00;
    ref_mem[32'h33] = 8'h00;
    repeat (3) step();
    single('{1'b1, 1'b0, MEM_DT_WORD, 32'h30, 32'h0, 32'h00000011, 1'b0}, 13);

    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < 2; k++) begin
        if (granted[k] || !req[k]) rand_port(k);
      end
      step();
    end
    req[0] = 1'b0;
    req[1] = 1'b0;
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
